aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer that drives the AES-128 key expansion datapath: en, gen_key, next_rnd and the round constant.
- Steps the datapath through 10 rounds, two cycles per round, matching its two pipeline registers.
- Flags each round key as it appears on the datapath key output.
- Sits between the cipher top-level control (start/abort) and the key expansion datapath. An optional key store keeps all 11 round keys for later lookup.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; counter width is 4 bits.
- RCON_INIT, 8'h01, round constant for round 1.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-high reset; all state is cleared on the clk edge where nrst=1.
- start  in  1  single-cycle request to begin expansion of the key currently on the datapath key input.
- abort  in  1  cancels an expansion in progress.
- busy  out  1  high from the first LOAD cycle through the last EXP cycle.
- done  out  1  one-cycle pulse after round NUM_ROUNDS key is valid.
- en  out  1  datapath pipeline enable.
- gen_key  out  1  selects controller round constant in the datapath.
- next_rnd  out  1  0 = datapath takes the external key, 1 = feeds back its own output.
- r_con_ctrl  out  32  round constant in bits [7:0]; bits [31:8] are always 0.
- rk_valid  out  1  datapath key output holds round key rk_idx this cycle.
- rk_idx  out  4  round index 1..NUM_ROUNDS.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round counter 0, rcon register = RCON_INIT.
- FSM states: IDLE, LOAD, FEED, EXP, DONE.
- IDLE:
  - en=0.
  - start=1 → LOAD, round=1, rcon=RCON_INIT.
- LOAD (round 1, stage 1):
  - en=1, next_rnd=0, gen_key=1.
  - Next state: EXP.
- FEED (round r>1, stage 1):
  - en=1, next_rnd=1, gen_key=1.
  - Next state: EXP.
- EXP (stage 2):
  - en=1, gen_key=1, next_rnd holds its stage-1 value.
  - Next state: DONE if round==NUM_ROUNDS, else FEED with round+1 and rcon=xtime(rcon).
- Round key visibility: in the cycle after EXP, the datapath key output holds round key r.
  - rk_valid=1, rk_idx=r in that cycle (registered).
  - In FEED, this coincides with feeding that key back.
- xtime: rcon<<1, then XOR 8'h1B if the old bit 7 was 1. Sequence: 01 02 04 08 10 20 40 80 1B 36.
- r_con_ctrl changes only on the EXP→FEED edge. It is therefore stable across both stages of a round.
  - This is required because the datapath applies rcon in the stage-2 combinational logic.
- DONE:
  - en=0, rk_valid=1 for the final key, done=1 for one cycle.
  - Next state: IDLE; busy=0 from the DONE cycle.
- Total latency: start to done = 2*NUM_ROUNDS+1 cycles (21). start accepted only in IDLE; ignored otherwise.
- abort, any non-IDLE state: next cycle IDLE, en=0, rk_valid=0, no done.
  - abort and start together in IDLE: abort wins, stay IDLE.
- nrst mid-operation: same as abort, plus rcon and counter reset.
- en=0 in IDLE/DONE, so the datapath holds its last key; key output stays stable after done.
- System requirement (not in this block): the S-box feeding the datapath substitution input is registered with the same en, so that input aligns with stage 2.

Optional Feature:
- Macro: AES_KEY_SCHED_STORE_EN.
- Defined: adds the following ports.
  - key_i (in, 128): external key.
  - key_o (in, 128): datapath output.
  - rd_idx (in, 4).
  - rd_key (out, 128, registered, 1-cycle read latency).
- Defined, storage: an 11×128 register array.
  - Entry 0 captured from key_i in LOAD.
  - Entry r captured from key_o when rk_valid=1.
  - rd_idx > 10 returns 0. Array is cleared to 0 on nrst.
  - A read of an entry in its write cycle returns the old value.
- Undefined: none of these ports or storage exist; control behaviour is identical.

Decomposition:
- Shared package aes_pkg:
  - aes_byte, aes_32, aes_128 typedefs.
  - FSM state enum.
  - RCON_INIT, AES_NUM_ROUNDS.
  - xtime function.
- One natural sub-module: aes_round_key_store (storage array plus read port), instantiated only under AES_KEY_SCHED_STORE_EN.

Test Plan:
- Reset then idle: nrst=1 for 2 cycles → all outputs 0; start held low 10 cycles → en stays 0.
- Full expansion with datapath and registered S-box, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start pulse:
  - rk_idx=1 with key_o=a0fafe17_88542cb1_23a33939_2a6c7605.
  - rk_idx=10 with key_o=d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - done exactly 21 cycles after start.
- Rcon trace: sample r_con_ctrl in each EXP cycle → 01,02,04,08,10,20,40,80,1B,36; bits [31:8]=0; value unchanged between FEED and its EXP.
- Abort at round 5 EXP → next cycle busy=0, en=0, no done. A new start then gives correct round-1 key and rcon=01.
- start asserted while busy at round 3 → ignored, sequence and done timing unchanged. abort+start together in IDLE → stays IDLE.
- With AES_KEY_SCHED_STORE_EN, after the full run:
  - rd_idx=0 → 2b7e1516…09cf4f3c one cycle later.
  - rd_idx=10 → d014f9a8…b6630ca6.
  - rd_idx=15 → 0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, constants, FSM encoding and
//               the GF(2^8) xtime helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef logic [7:0]   aes_byte;
  typedef logic [31:0]  aes_32;
  typedef logic [127:0] aes_128;

  localparam int      AES_NUM_ROUNDS = 10;
  localparam aes_byte RCON_INIT      = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FEED = 3'd2,
    ST_EXP  = 3'd3,
    ST_DONE = 3'd4
  } key_sched_state_e;

  function automatic aes_byte xtime(input aes_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_key_store.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_store
// Description : Register array holding every expanded round key, with a
//               registered read port (one-cycle latency, read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key_store
  import aes_pkg::*;
#(
  parameter int NUM_KEYS = AES_NUM_ROUNDS + 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_load,
  input  logic [127:0] i_key_ext,
  input  logic         i_rk_valid,
  input  logic [3:0]   i_rk_idx,
  input  logic [127:0] i_key_dp,
  input  logic [3:0]   i_rd_idx,
  output logic [127:0] o_rd_key
);

  aes_128 r_mem [NUM_KEYS];
  aes_128 r_rd_key;

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_key <= '0;
    end else begin
      if (i_load) begin
        r_mem[0] <= i_key_ext;
      end
      if (i_rk_valid && (int'(i_rk_idx) < NUM_KEYS)) begin
        r_mem[i_rk_idx] <= i_key_dp;
      end
      r_rd_key <= (int'(i_rd_idx) < NUM_KEYS) ? r_mem[i_rd_idx] : '0;
    end
  end

  assign o_rd_key = r_rd_key;

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Sequencer for the two-stage AES-128 key expansion datapath.
//               Optional round-key store enabled by AES_KEY_SCHED_STORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int      NUM_ROUNDS = aes_pkg::AES_NUM_ROUNDS,
  parameter aes_byte RCON_INIT  = aes_pkg::RCON_INIT
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         en,
  output logic         gen_key,
  output logic         next_rnd,
  output logic [31:0]  r_con_ctrl,
  output logic         rk_valid,
  output logic [3:0]   rk_idx
`ifdef AES_KEY_SCHED_STORE_EN
  ,
  input  logic [127:0] key_i,
  input  logic [127:0] key_o,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

  key_sched_state_e r_state;
  logic [3:0]       r_round;
  aes_byte          r_rcon;
  aes_byte          r_rcon_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_en;
  logic             r_gen_key;
  logic             r_next_rnd;
  logic             r_rk_valid;
  logic [3:0]       r_rk_idx;

  // r_rcon_nxt runs one round ahead so r_rcon only ever loads a register value.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= ST_IDLE;
      r_round    <= '0;
      r_rcon     <= '0;
      r_rcon_nxt <= RCON_INIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_en       <= 1'b0;
      r_gen_key  <= 1'b0;
      r_next_rnd <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_idx   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_idx   <= '0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_en       <= 1'b0;
        r_gen_key  <= 1'b0;
        r_next_rnd <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_state    <= ST_LOAD;
              r_round    <= 4'd1;
              r_rcon     <= RCON_INIT;
              r_rcon_nxt <= xtime(RCON_INIT);
              r_busy     <= 1'b1;
              r_en       <= 1'b1;
              r_gen_key  <= 1'b1;
              r_next_rnd <= 1'b0;
            end
          end
          ST_LOAD, ST_FEED: begin
            r_state <= ST_EXP;
          end
          ST_EXP: begin
            r_rk_valid <= 1'b1;
            r_rk_idx   <= r_round;
            if (r_round == c_last_round) begin
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_en       <= 1'b0;
              r_gen_key  <= 1'b0;
              r_next_rnd <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= ST_FEED;
              r_round    <= r_round + 4'd1;
              r_rcon     <= r_rcon_nxt;
              r_rcon_nxt <= xtime(r_rcon_nxt);
              r_next_rnd <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign en         = r_en;
  assign gen_key    = r_gen_key;
  assign next_rnd   = r_next_rnd;
  assign r_con_ctrl = {24'h0, r_rcon};
  assign rk_valid   = r_rk_valid;
  assign rk_idx     = r_rk_idx;

`ifdef AES_KEY_SCHED_STORE_EN
  logic w_load;
  assign w_load = (r_state == ST_LOAD);

  aes_round_key_store #(
    .NUM_KEYS (NUM_ROUNDS + 1)
  ) u_key_store (
    .clk        (clk),
    .nrst       (nrst),
    .i_load     (w_load),
    .i_key_ext  (key_i),
    .i_rk_valid (r_rk_valid),
    .i_rk_idx   (r_rk_idx),
    .i_key_dp   (key_o),
    .i_rd_idx   (rd_idx),
    .o_rd_key   (rd_key)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Bench for aes_key_sched_ctrl with a two-stage key datapath
//               and registered S-box, scoreboard of round keys and rcon.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] c_key  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] c_rk1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] c_rk10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  logic         clk = 1'b0;
  logic         nrst, start, abort;
  logic         busy, done, en, gen_key, next_rnd, rk_valid;
  logic [31:0]  r_con_ctrl;
  logic [3:0]   rk_idx;
  logic [127:0] key_i, key_o, s1_key;
  logic [31:0]  s1_sub;
`ifdef AES_KEY_SCHED_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] rc_q[$];

  logic [7:0]   c_rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] rk_sw [11];
  bit           phase = 1'b0;
  logic [31:0]  rc_s1;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .en         (en),
    .gen_key    (gen_key),
    .next_rnd   (next_rnd),
    .r_con_ctrl (r_con_ctrl),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx)
`ifdef AES_KEY_SCHED_STORE_EN
    ,
    .key_i      (key_i),
    .key_o      (key_o),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x = 8'h01;
    repeat (254) x = gmul(x, b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [31:0] sw,
                                          input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sw ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Datapath: stage 1 captures the key and its S-box word, stage 2 combines with rcon.
  always @(posedge clk) begin
    if (nrst) begin
      s1_key <= '0;
      s1_sub <= '0;
      key_o  <= '0;
    end else if (en) begin
      s1_key <= next_rnd ? key_o : key_i;
      s1_sub <= subrot(next_rnd ? key_o[31:0] : key_i[31:0]);
      key_o  <= expand(s1_key, s1_sub, r_con_ctrl[7:0]);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          check("rk_unexpected", rk_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rk_idx", rk_idx, e.idx);
          check("rk_key", key_o, e.key);
        end
      end
      if (en) begin
        if (!phase) begin
          rc_s1 = r_con_ctrl;
          phase = 1'b1;
        end else begin
          phase = 1'b0;
          if (rc_q.size() == 0) check("rcon_unexpected", en, 0);
          else begin
            check("rcon", r_con_ctrl, {24'h0, rc_q.pop_front()});
            check("rcon_stable", r_con_ctrl, rc_s1);
          end
        end
      end else begin
        phase = 1'b0;
      end
      if (done) n_done++;
    end else begin
      phase = 1'b0;
    end
  end

  task automatic run(input int start_at, input int abort_at, output int done_at);
    int done0;
    for (int r = 1; r <= 10; r++) begin
      exp_q.push_back('{idx: 4'(r), key: rk_sw[r]});
      rc_q.push_back(c_rcon[r-1]);
    end
    done_at = -1;
    done0   = n_done;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == start_at);
      abort = (n == abort_at);
      if (abort_at > 0 && n == abort_at + 1) begin
        check("abort_busy", busy, 0);
        check("abort_en", en, 0);
        check("abort_rkv", rk_valid, 0);
      end
      if (rk_valid && rk_idx == 4'd1) check("rk1_value", key_o, c_rk1);
      if (done && done_at < 0) begin
        done_at = n;
        check("done_rkidx", rk_idx, 10);
        check("done_rkv", rk_valid, 1);
        check("done_en", en, 0);
        check("done_busy", busy, 0);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at > 0) begin
      check("abort_no_done", n_done - done0, 0);
      exp_q.delete();
      rc_q.delete();
    end else begin
      check("done_pulses", n_done - done0, 1);
    end
  endtask

  initial begin
    int d;
    nrst  = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    key_i = c_key;
`ifdef AES_KEY_SCHED_STORE_EN
    rd_idx = 4'd0;
`endif
    rk_sw[0] = c_key;
    for (int r = 1; r <= 10; r++) rk_sw[r] = expand(rk_sw[r-1], subrot(rk_sw[r-1][31:0]), c_rcon[r-1]);

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", en, 0);
    check("rst_gen_key", gen_key, 0);
    check("rst_next_rnd", next_rnd, 0);
    check("rst_rcon", r_con_ctrl, 0);
    check("rst_rk_valid", rk_valid, 0);
    check("rst_rk_idx", rk_idx, 0);
    nrst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_en", en, 0);
    end

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_start_busy", busy, 0);
      check("abort_start_en", en, 0);
    end

    run(0, 0, d);
    check("done_lat", d, 21);
    check("final_key", key_o, c_rk10);
    repeat (3) @(negedge clk);
    check("key_hold", key_o, c_rk10);

    run(5, 0, d);
    check("busy_start_lat", d, 21);

    run(0, 10, d);
    check("abort_done_none", d, -1);

    run(0, 0, d);
    check("restart_lat", d, 21);
    check("restart_final", key_o, c_rk10);

`ifdef AES_KEY_SCHED_STORE_EN
    rd_idx = 4'd0;
    @(negedge clk);
    check("store_0", rd_key, c_key);
    rd_idx = 4'd10;
    @(negedge clk);
    check("store_10", rd_key, c_rk10);
    rd_idx = 4'd5;
    @(negedge clk);
    check("store_5", rd_key, rk_sw[5]);
    rd_idx = 4'd15;
    @(negedge clk);
    check("store_15", rd_key, 0);
`endif

    check("sb_rk_empty", exp_q.size(), 0);
    check("sb_rc_empty", rc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
